// File: rtl/mayo_shake_sponge_ctrl_if.sv
// Control, BRAM port A and lane-serial Keccak core signals of the MAYO SHAKE sponge controller.
// master = sponge controller, slave = environment (BRAM, Keccak core, requester).
interface mayo_shake_sponge_ctrl_if #(
    parameter int C_BRAMSIZE = 13
);
    logic                  en;
    logic                  mode;
    logic [31:0]           mlen;
    logic [31:0]           olen;
    logic [31:0]           read_adr;
    logic [31:0]           write_adr;
    logic                  busy;
    logic                  dyn_done;
    logic                  done;

    logic                  bram_en;
    logic [3:0]            bram_we;
    logic [C_BRAMSIZE:0]   bram_addr;
    logic [31:0]           bram_din;
    logic [31:0]           bram_dout;

    logic                  st_clr;
    logic                  st_wr;
    logic [4:0]            st_idx;
    logic [63:0]           st_wdata;
    logic [63:0]           st_rdata;
    logic                  perm_start;
    logic                  perm_done;

    modport master (
        input  en, mode, mlen, olen, read_adr, write_adr, bram_dout, st_rdata, perm_done,
        output busy, dyn_done, done, bram_en, bram_we, bram_addr, bram_din,
               st_clr, st_wr, st_idx, st_wdata, perm_start
    );

    modport slave (
        output en, mode, mlen, olen, read_adr, write_adr, bram_dout, st_rdata, perm_done,
        input  busy, dyn_done, done, bram_en, bram_we, bram_addr, bram_din,
               st_clr, st_wr, st_idx, st_wdata, perm_start
    );
endinterface

// File: rtl/mayo_shake_sponge_ctrl.sv
// SHAKE128/256 sponge sequencer: absorbs a padded BRAM message into an external lane-serial
// Keccak core and squeezes the requested number of output bytes back into BRAM.
module mayo_shake_sponge_ctrl #(
    parameter int          C_BRAMSIZE = 13,
    parameter logic [7:0]  C_DOMAIN   = 8'h1F
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    mayo_shake_sponge_ctrl_if.master io_bus
);
    localparam int AW = C_BRAMSIZE + 1;

    typedef enum logic [3:0] {
        S_IDLE, S_CLR, S_ABS_RD, S_ABS_LANE, S_PERM, S_PERM_WAIT,
        S_SQ_LANE, S_SQ_WR, S_SQ_DYN, S_DONE
    } state_t;

    state_t           r_state, w_state_nxt;
    logic             r_mode, r_half, r_sq;
    logic [31:0]      r_mlen, r_olen, r_blk_off, r_out_cnt, r_lo;
    logic [AW-1:0]    r_rd_base, r_wr_base;
    logic [4:0]       r_lane;
    logic [63:0]      r_sq_data;

    logic [4:0]       w_rate_lanes;
    logic [31:0]      w_rate, w_rem, w_lane_off, w_word_off, w_out_rem, w_q;
    logic             w_final, w_fetch, w_last_lane;
    logic [63:0]      w_raw, w_lane_data;
    logic [7:0]       w_byte;

    assign w_rate_lanes = r_mode ? 5'd17 : 5'd21;
    assign w_rate       = r_mode ? 32'd136 : 32'd168;
    assign w_rem        = r_mlen - r_blk_off;
    assign w_final      = (w_rem < w_rate);
    assign w_lane_off   = {24'd0, r_lane, 3'd0};
    assign w_word_off   = w_lane_off + {29'd0, r_half, 2'd0};
    assign w_fetch      = (w_word_off < w_rem);
    assign w_last_lane  = (r_lane == w_rate_lanes - 5'd1);
    assign w_out_rem    = r_olen - r_out_cnt;
    assign w_raw        = {io_bus.bram_dout, r_lo};

    // Bytes past the message end are zeroed before the domain byte and final 0x80 are folded in.
    always_comb begin
        w_lane_data = '0;
        w_q         = '0;
        w_byte      = '0;
        for (int b = 0; b < 8; b++) begin
            w_q    = w_lane_off + 32'(b);
            w_byte = (w_q < w_rem) ? w_raw[8*b +: 8] : 8'h00;
            if (w_q == w_rem)
                w_byte = w_byte ^ C_DOMAIN;
            if (w_final && (w_q == w_rate - 32'd1))
                w_byte = w_byte ^ 8'h80;
            w_lane_data[8*b +: 8] = w_byte;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt        = r_state;
        io_bus.busy        = 1'b0;
        io_bus.dyn_done    = 1'b0;
        io_bus.done        = 1'b0;
        io_bus.bram_en     = 1'b0;
        io_bus.bram_we     = 4'h0;
        io_bus.bram_addr   = '0;
        io_bus.bram_din    = 32'h0;
        io_bus.st_clr      = 1'b0;
        io_bus.st_wr       = 1'b0;
        io_bus.st_idx      = 5'd0;
        io_bus.st_wdata    = 64'h0;
        io_bus.perm_start  = 1'b0;
        if (r_state != S_IDLE && r_state != S_DONE)
            io_bus.busy = 1'b1;
        case (r_state)
            S_IDLE: if (io_bus.en) w_state_nxt = S_CLR;
            S_CLR: begin
                io_bus.st_clr = 1'b1;
                w_state_nxt   = S_ABS_RD;
            end
            S_ABS_RD: begin
                io_bus.bram_en   = w_fetch;
                io_bus.bram_addr = r_rd_base + r_blk_off[AW-1:0] + w_word_off[AW-1:0];
                if (r_half) w_state_nxt = S_ABS_LANE;
            end
            S_ABS_LANE: begin
                io_bus.st_wr    = 1'b1;
                io_bus.st_idx   = r_lane;
                io_bus.st_wdata = w_lane_data;
                w_state_nxt     = w_last_lane ? S_PERM : S_ABS_RD;
            end
            S_PERM: begin
                io_bus.perm_start = 1'b1;
                w_state_nxt       = S_PERM_WAIT;
            end
            S_PERM_WAIT: if (io_bus.perm_done) begin
                if (!r_sq && !w_final)
                    w_state_nxt = S_ABS_RD;
                else
                    w_state_nxt = (r_out_cnt >= r_olen) ? S_DONE : S_SQ_LANE;
            end
            S_SQ_LANE: begin
                io_bus.st_idx = r_lane;
                w_state_nxt   = S_SQ_WR;
            end
            S_SQ_WR: begin
                io_bus.bram_en   = 1'b1;
                io_bus.bram_addr = r_wr_base + r_out_cnt[AW-1:0];
                io_bus.bram_din  = r_half ? r_sq_data[63:32] : r_sq_data[31:0];
                if (w_out_rem >= 32'd4)
                    io_bus.bram_we = 4'hF;
                else case (w_out_rem[1:0])
                    2'd1:    io_bus.bram_we = 4'b0001;
                    2'd2:    io_bus.bram_we = 4'b0011;
                    default: io_bus.bram_we = 4'b0111;
                endcase
                if (w_out_rem <= 32'd4 || (r_half && w_last_lane))
                    w_state_nxt = S_SQ_DYN;
                else
                    w_state_nxt = r_half ? S_SQ_LANE : S_SQ_WR;
            end
            S_SQ_DYN: begin
                io_bus.dyn_done = 1'b1;
                w_state_nxt     = (r_out_cnt >= r_olen) ? S_DONE : S_PERM;
            end
            S_DONE: begin
                io_bus.done = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mode    <= 1'b0;
            r_mlen    <= '0;
            r_olen    <= '0;
            r_rd_base <= '0;
            r_wr_base <= '0;
            r_blk_off <= '0;
            r_out_cnt <= '0;
            r_lane    <= '0;
            r_half    <= 1'b0;
            r_sq      <= 1'b0;
            r_lo      <= '0;
            r_sq_data <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (io_bus.en) begin
                    r_mode    <= io_bus.mode;
                    r_mlen    <= io_bus.mlen;
                    r_olen    <= io_bus.olen;
                    r_rd_base <= {io_bus.read_adr[AW-1:2], 2'b00};
                    r_wr_base <= {io_bus.write_adr[AW-1:2], 2'b00};
                    r_blk_off <= '0;
                    r_out_cnt <= '0;
                    r_lane    <= '0;
                    r_half    <= 1'b0;
                    r_sq      <= 1'b0;
                end
                S_ABS_RD: begin
                    r_half <= ~r_half;
                    if (r_half) r_lo <= io_bus.bram_dout;
                end
                S_ABS_LANE: r_lane <= w_last_lane ? 5'd0 : r_lane + 5'd1;
                S_PERM_WAIT: if (io_bus.perm_done) begin
                    if (!r_sq && !w_final)
                        r_blk_off <= r_blk_off + w_rate;
                    else
                        r_sq <= 1'b1;
                    r_lane <= '0;
                    r_half <= 1'b0;
                end
                S_SQ_LANE: r_sq_data <= io_bus.st_rdata;
                S_SQ_WR: begin
                    r_out_cnt <= r_out_cnt + 32'd4;
                    r_half    <= ~r_half;
                    if (r_half) r_lane <= w_last_lane ? 5'd0 : r_lane + 5'd1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mayo_shake_sponge_ctrl.sv
// Directed bench: BRAM and Keccak core stand-ins, absorbed lanes and squeezed writes checked
// against hand-computed values.
module tb_mayo_shake_sponge_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mayo_shake_sponge_ctrl_if #(.C_BRAMSIZE(13)) u_bus();

    mayo_shake_sponge_ctrl #(.C_BRAMSIZE(13), .C_DOMAIN(8'h1F)) u_dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .io_bus  (u_bus.master)
    );

    logic [31:0] mem [0:4095];
    logic [63:0] st_m [0:31];
    logic [1:0]  pcnt;

    always @(posedge clk)
        if (u_bus.bram_en && u_bus.bram_we == 4'h0)
            u_bus.bram_dout <= mem[u_bus.bram_addr[13:2]];

    // Core stand-in: the permutation is an arbitrary lane mix so squeezed data is nontrivial.
    always @(posedge clk) begin
        u_bus.perm_done <= 1'b0;
        if (!rst_n)
            pcnt <= 2'd0;
        else if (u_bus.perm_start)
            pcnt <= 2'd3;
        else if (pcnt != 2'd0) begin
            pcnt <= pcnt - 2'd1;
            if (pcnt == 2'd1) u_bus.perm_done <= 1'b1;
        end
        if (u_bus.st_clr) begin
            for (int i = 0; i < 32; i++) st_m[i] <= 64'h0;
        end else if (u_bus.st_wr)
            st_m[u_bus.st_idx] <= st_m[u_bus.st_idx] ^ u_bus.st_wdata;
        else if (rst_n && pcnt == 2'd1 && !u_bus.perm_start) begin
            for (int i = 0; i < 25; i++)
                st_m[i] <= {st_m[i][50:0], st_m[i][63:51]} ^ (64'h9E37_79B9_7F4A_7C15 * 64'(i + 1));
        end
    end

    assign u_bus.st_rdata = st_m[u_bus.st_idx];

    int n_chk = 0;
    int n_bad = 0;
    int n_stwr, n_perm, n_rd, n_wr, n_dyn, n_done;
    logic [3:0]  last_we;
    logic [63:0] ab [0:1][0:24];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_bram"}, {13'd0, u_bus.bram_en, u_bus.bram_we, u_bus.bram_addr, u_bus.bram_din}, 64'h0);
        chk({tag, "_ctl"}, {52'd0, u_bus.busy, u_bus.done, u_bus.dyn_done, u_bus.st_clr, u_bus.st_wr,
                            u_bus.st_idx, u_bus.perm_start}, 64'h0);
        chk({tag, "_wdata"}, u_bus.st_wdata, 64'h0);
    endtask

    task automatic run_op(input logic m, input logic [31:0] ml, input logic [31:0] ol,
                          input logic [31:0] ra, input logic [31:0] wa, input bit abort);
        int rw, ln, cyc;
        logic [31:0] rem;
        logic [13:0] off, exp_a;
        logic [3:0]  we_e;
        logic [31:0] exp_d;
        n_stwr = 0; n_perm = 0; n_rd = 0; n_wr = 0; n_dyn = 0; n_done = 0; last_we = 4'h0;
        for (int b = 0; b < 2; b++)
            for (int i = 0; i < 25; i++) ab[b][i] = 64'h0;
        rw = m ? 34 : 42;
        @(negedge clk);
        u_bus.en = 1'b1; u_bus.mode = m; u_bus.mlen = ml; u_bus.olen = ol;
        u_bus.read_adr = ra; u_bus.write_adr = wa;
        @(negedge clk);
        u_bus.en = 1'b0;
        chk("busy_start", {63'd0, u_bus.busy}, 64'd1);
        cyc = 0;
        while (n_done == 0 && cyc < 4000) begin
            if (u_bus.st_wr) begin
                if (n_perm < 2) ab[n_perm][u_bus.st_idx] = u_bus.st_wdata;
                n_stwr++;
            end
            if (u_bus.perm_start) n_perm++;
            if (u_bus.bram_en) begin
                if (u_bus.bram_we == 4'h0) begin
                    off = u_bus.bram_addr - 14'(ra & 32'hFFFF_FFFC);
                    chk("rd_in_msg", {63'd0, 32'(off) < ml}, 64'd1);
                    chk("rd_din_zero", {32'd0, u_bus.bram_din}, 64'h0);
                    n_rd++;
                end else begin
                    ln    = (n_wr % rw) / 2;
                    exp_d = (n_wr % 2 == 1) ? st_m[ln][63:32] : st_m[ln][31:0];
                    rem   = ol - 32'(4 * n_wr);
                    we_e  = (rem >= 32'd4) ? 4'hF : 4'((5'd1 << rem[1:0]) - 5'd1);
                    exp_a = 14'((wa & 32'hFFFF_FFFC) + 32'(4 * n_wr));
                    chk("wr_addr", {50'd0, u_bus.bram_addr}, {50'd0, exp_a});
                    chk("wr_we", {60'd0, u_bus.bram_we}, {60'd0, we_e});
                    chk("wr_din", {32'd0, u_bus.bram_din}, {32'd0, exp_d});
                    last_we = u_bus.bram_we;
                    n_wr++;
                    if (abort) begin
                        rst_n = 1'b0;
                        #1;
                        chk_outputs_zero("rst_mid");
                        return;
                    end
                end
            end
            if (u_bus.dyn_done) n_dyn++;
            if (u_bus.done) begin
                n_done++;
                chk("busy_at_done", {63'd0, u_bus.busy}, 64'd0);
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        chk("done_seen", 64'(n_done), 64'd1);
    endtask

    initial begin
        u_bus.en = 1'b0; u_bus.mode = 1'b0; u_bus.mlen = '0; u_bus.olen = '0;
        u_bus.read_adr = '0; u_bus.write_adr = '0;
        for (int i = 0; i < 4096; i++) mem[i] = 32'h1000_0000 + 32'(i) * 32'h0001_0003;
        mem[0] = 32'hD808_EE98; mem[1] = 32'h3852_0EBA; mem[2] = 32'h6F3C_21A7;
        mem[3] = 32'h0B95_D4E2; mem[4] = 32'h5AC7_103F; mem[5] = 32'hE126_4B8D;
        mem[6] = 32'hA84F_7D23;
        repeat (3) @(negedge clk);
        chk_outputs_zero("reset");
        rst_n = 1'b1;

        // empty message, SHAKE128, one 32-byte output block
        run_op(1'b0, 32'd0, 32'd32, 32'h0, 32'h200, 1'b0);
        for (int i = 0; i < 21; i++)
            chk("t1_lane", ab[0][i], (i == 0) ? 64'h1F : (i == 20) ? 64'h8000_0000_0000_0000 : 64'h0);
        chk("t1_stwr", 64'(n_stwr), 64'd21);
        chk("t1_perm", 64'(n_perm), 64'd1);
        chk("t1_wr", 64'(n_wr), 64'd8);
        chk("t1_dyn", 64'(n_dyn), 64'd1);
        chk("t1_rd", 64'(n_rd), 64'd0);

        // 28-byte message, SHAKE256
        run_op(1'b1, 32'd28, 32'd32, 32'h0, 32'd32, 1'b0);
        chk("t2_lane0", ab[0][0], 64'h3852_0EBA_D808_EE98);
        chk("t2_lane1", ab[0][1], 64'h0B95_D4E2_6F3C_21A7);
        chk("t2_lane3", ab[0][3], 64'h0000_001F_A84F_7D23);
        chk("t2_lane4", ab[0][4], 64'h0);
        chk("t2_lane16", ab[0][16], 64'h8000_0000_0000_0000);
        chk("t2_rd", 64'(n_rd), 64'd7);
        chk("t2_wr", 64'(n_wr), 64'd8);

        // 135 bytes: domain and final pad share the last rate byte
        run_op(1'b1, 32'd135, 32'd8, 32'h0, 32'h1000, 1'b0);
        chk("t3_lane16", ab[0][16], {(mem[33] & 32'h00FF_FFFF) | 32'h9F00_0000, mem[32]});
        chk("t3_rd", 64'(n_rd), 64'd34);
        chk("t3_perm", 64'(n_perm), 64'd1);
        chk("t3_stwr", 64'(n_stwr), 64'd17);
        chk("t3_wr", 64'(n_wr), 64'd2);

        // exactly one rate block: extra pad-only block
        run_op(1'b1, 32'd136, 32'd4, 32'h0, 32'h1000, 1'b0);
        chk("t4_perm", 64'(n_perm), 64'd2);
        chk("t4_rd", 64'(n_rd), 64'd34);
        chk("t4_stwr", 64'(n_stwr), 64'd34);
        chk("t4_b0_lane16", ab[0][16], {mem[33], mem[32]});
        for (int i = 0; i < 17; i++)
            chk("t4_b1_lane", ab[1][i], (i == 0) ? 64'h1F : (i == 16) ? 64'h8000_0000_0000_0000 : 64'h0);
        chk("t4_wr", 64'(n_wr), 64'd1);

        // multi-block squeeze, unaligned read base, write address wraps the BRAM
        run_op(1'b0, 32'd4, 32'd170, 32'h103, 32'h3F80, 1'b0);
        chk("t5_lane0", ab[0][0], {32'h0000_001F, mem[64]});
        chk("t5_lane20", ab[0][20], 64'h8000_0000_0000_0000);
        chk("t5_perm", 64'(n_perm), 64'd2);
        chk("t5_wr", 64'(n_wr), 64'd43);
        chk("t5_last_we", {60'd0, last_we}, 64'h3);
        chk("t5_dyn", 64'(n_dyn), 64'd2);
        chk("t5_rd", 64'(n_rd), 64'd1);

        // reset during squeeze, then a clean restart
        run_op(1'b0, 32'd4, 32'd64, 32'h0, 32'h400, 1'b1);
        repeat (2) @(negedge clk);
        chk_outputs_zero("rst_hold");
        rst_n = 1'b1;
        run_op(1'b0, 32'd0, 32'd32, 32'h0, 32'h200, 1'b0);
        chk("t6_lane0", ab[0][0], 64'h1F);
        chk("t6_wr", 64'(n_wr), 64'd8);
        chk("t6_dyn", 64'(n_dyn), 64'd1);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
